// File: rtl/syx_dump_reader_pkg.sv
// syx_pkg: shared SysEx framing constants, dump FSM state type and bank-walk helper
package syx_pkg;
  localparam logic [7:0] SYX_SOX = 8'hF0;
  localparam logic [7:0] SYX_EOX = 8'hF7;
  localparam logic [7:0] SYX_DATA_MASK = 8'h7F;
  typedef enum logic [3:0] {IDLE, HDR, RD_ISSUE, RD_WAIT, SEND, CKSUM, EOX, NEXT, FIN} syx_dump_state_t;
  // First bank at or above 'from' that is below 'banks' and not masked; returns 'banks' if none.
  function automatic logic [3:0] syx_next_bank(input logic [7:0] mask, input int banks, input int from);
    logic [3:0] r;
    r = 4'(banks);
    for (int b = 7; b >= 0; b--)
      if (b >= from && b < banks && !mask[b]) r = 4'(b);
    return r;
  endfunction
endpackage

// File: rtl/syx_dump_reader_if.sv
// syx_dump_reader_if: bank decoder read port plus MIDI TX byte handshake
interface syx_dump_reader_if;
  logic [2:0] dec_addr;
  logic [6:0] par_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output dec_addr, par_addr, rd_en, tx_data, tx_valid, input rd_data, tx_ready);
  modport slave (input dec_addr, par_addr, rd_en, tx_data, tx_valid, output rd_data, tx_ready);
endinterface

// File: rtl/syx_dump_reader_tx_hold.sv
// syx_tx_hold: single-entry valid/ready output register holding a byte until TX accepts it
module syx_tx_hold (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       empty,
  output logic       free
);
  assign empty = !tx_valid;
  assign free = !tx_valid || tx_ready;
  // Load only happens when free, so a pending byte is never overwritten or withdrawn.
  always_ff @(posedge CLOCK_25 or posedge reset)
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data <= din;
    end else if (tx_ready) tx_valid <= 1'b0;
endmodule

// File: rtl/syx_dump_reader.sv
// syx_dump_reader: walks enabled parameter banks and emits one SysEx dump per bank; SYX_DUMP_CKSUM_EN adds a checksum byte
module syx_dump_reader
  import syx_pkg::*;
#(
  parameter int         BANKS = 6,
  parameter int         PARS_PER_BANK = 64,
  parameter logic [7:0] SKIP_MASK = 8'b0001_0000,
  parameter int         RD_LAT = 2,
  parameter logic [7:0] MFR_ID = 8'h7D,
  parameter logic [7:0] DEV_ID = 8'h00
) (
  input  logic                CLOCK_25,
  input  logic                reset,
  input  logic                dump_req,
  output logic                busy,
  output logic                done,
  syx_dump_reader_if.master   bus
);
  localparam logic [3:0] NB = 4'(BANKS);
  localparam logic [3:0] FIRST = syx_next_bank(SKIP_MASK, BANKS, 0);
  localparam logic [6:0] LAST = 7'(PARS_PER_BANK - 1);
  syx_dump_state_t state;
  logic [2:0] bank;
  logic [6:0] par;
  logic       rd;
  logic [1:0] hdr_idx, cnt;
  logic [7:0] cap, din, hdr_byte, cksum;
  logic [3:0] nxt;
  logic       load, free, empty;
`ifdef SYX_DUMP_CKSUM_EN
  logic [7:0] acc;
  assign cksum = (8'h00 - acc) & SYX_DATA_MASK;
`else
  assign cksum = SYX_EOX;
`endif
  assign bus.dec_addr = bank;
  assign bus.par_addr = par;
  assign bus.rd_en = rd;
  assign nxt = syx_next_bank(SKIP_MASK, BANKS, int'(bank) + 1);
  assign hdr_byte = hdr_idx == 2'd0 ? SYX_SOX : hdr_idx == 2'd1 ? MFR_ID : hdr_idx == 2'd2 ? DEV_ID : {5'b0, bank};
  assign din = state == IDLE ? SYX_SOX : state == HDR ? hdr_byte : state == EOX ? SYX_EOX : state == CKSUM ? cksum : cap;
  // F0 is loaded straight from IDLE so it is on the bus the cycle after dump_req.
  assign load = state == IDLE ? dump_req && FIRST < NB : (state inside {HDR, SEND, CKSUM, EOX}) && free;
  syx_tx_hold u_hold (
    .CLOCK_25(CLOCK_25),
    .reset(reset),
    .load(load),
    .din(din),
    .tx_ready(bus.tx_ready),
    .tx_data(bus.tx_data),
    .tx_valid(bus.tx_valid),
    .empty(empty),
    .free(free)
  );
  // Dump sequencer: header, per-slot read/capture/send, optional checksum, F7, then next enabled bank.
  always_ff @(posedge CLOCK_25 or posedge reset)
    if (reset) begin
      state <= IDLE;
      bank <= 3'd0;
      par <= 7'd0;
      rd <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      hdr_idx <= 2'd0;
      cnt <= 2'd0;
      cap <= 8'h00;
`ifdef SYX_DUMP_CKSUM_EN
      acc <= 8'h00;
`endif
    end else begin
      rd <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE:
          if (dump_req) begin
            if (FIRST < NB) begin
              busy <= 1'b1;
              bank <= FIRST[2:0];
              par <= 7'd0;
              hdr_idx <= 2'd1;
              state <= HDR;
            end else done <= 1'b1;
          end
        HDR:
          if (free) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              rd <= 1'b1;
              state <= RD_ISSUE;
`ifdef SYX_DUMP_CKSUM_EN
              acc <= {5'b0, bank};
`endif
            end
          end
        RD_ISSUE: begin
          cnt <= 2'd0;
          state <= RD_WAIT;
        end
        RD_WAIT:
          if (cnt == 2'(RD_LAT - 1)) begin
            cap <= bus.rd_data & SYX_DATA_MASK;
            state <= SEND;
          end else cnt <= cnt + 2'd1;
        SEND:
          if (free) begin
`ifdef SYX_DUMP_CKSUM_EN
            acc <= acc + cap;
`endif
            if (par == LAST) begin
`ifdef SYX_DUMP_CKSUM_EN
              state <= CKSUM;
`else
              state <= EOX;
`endif
            end else begin
              par <= par + 7'd1;
              rd <= 1'b1;
              state <= RD_ISSUE;
            end
          end
        CKSUM: if (free) state <= EOX;
        EOX: if (free) state <= NEXT;
        NEXT:
          if (nxt < NB) begin
            bank <= nxt[2:0];
            par <= 7'd0;
            hdr_idx <= 2'd0;
            state <= HDR;
          end else state <= FIN;
        FIN:
          if (empty) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_syx_dump_reader.sv
// tb_syx_dump_reader: directed dumps checked byte-by-byte against a message-level model
module tb_syx_dump_reader;
  localparam int BANKS = 6, PPB = 4, RD_LAT = 2, NMSG = 5;
  localparam logic [7:0] SKIP = 8'b0001_0000;
`ifdef SYX_DUMP_CKSUM_EN
  localparam int MSG = PPB + 6;
`else
  localparam int MSG = PPB + 5;
`endif
  logic CLOCK_25 = 0, reset = 1, dump_req = 0;
  logic busy, done;
  syx_dump_reader_if bus ();
  syx_dump_reader #(.BANKS(BANKS), .PARS_PER_BANK(PPB), .SKIP_MASK(SKIP), .RD_LAT(RD_LAT),
                    .MFR_ID(8'h7D), .DEV_ID(8'h00)) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .dump_req(dump_req), .busy(busy), .done(done), .bus(bus));
  always #20 CLOCK_25 = ~CLOCK_25;

  int n_chk = 0, n_pass = 0, cyc = 0, dones = 0, mem_mode = 0;
  bit bp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  int rx_t[$];
  logic [7:0] p0 = 8'h00, p1 = 8'h00, prev_data = 8'h00;
  logic stall_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] mem_val(int mode, int b, int s);
    return mode == 0 ? 8'(8'h10 + b * 4 + s) : mode == 1 ? 8'hFF : 8'(s + 1);
  endfunction

  function automatic logic [7:0] rxb(int i);
    return (i >= 0 && i < rx.size()) ? rx[i] : 8'hxx;
  endfunction

  function automatic int rxt(int i);
    return (i >= 0 && i < rx_t.size()) ? rx_t[i] : -1;
  endfunction

  task automatic build(input int mode);
    logic [7:0] d;
    int sum;
    for (int b = 0; b < BANKS; b++) begin
      if (SKIP[b]) continue;
      exp_q.push_back(8'hF0); exp_q.push_back(8'h7D); exp_q.push_back(8'h00); exp_q.push_back(8'(b));
      sum = b;
      for (int s = 0; s < PPB; s++) begin
        d = mem_val(mode, b, s) & 8'h7F;
        exp_q.push_back(d);
        sum += d;
      end
`ifdef SYX_DUMP_CKSUM_EN
      exp_q.push_back(8'((-sum) & 8'h7F));
`endif
      exp_q.push_back(8'hF7);
    end
  endtask

  // Parameter RAM: value for the address presented with rd_en appears RD_LAT cycles later, junk otherwise.
  always @(posedge CLOCK_25) begin
    cyc <= cyc + 1;
    p0 <= bus.rd_en ? mem_val(mem_mode, int'(bus.dec_addr), int'(bus.par_addr)) : 8'hC3;
    p1 <= p0;
  end
  assign bus.rd_data = p1;

  // Compare process: every accepted byte against the model, plus hold stability while stalled.
  always @(negedge CLOCK_25) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 32'd1);
        else chk("stream", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        rx.push_back(bus.tx_data);
        rx_t.push_back(cyc);
      end
      if (done) dones++;
      stall_prev = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
    end
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge CLOCK_25);
      #1 bus.tx_ready = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic run_dump(input int mode, input bit midreq, output int base);
    int n, d0;
    base = rx.size();
    d0 = dones;
    mem_mode = mode;
    build(mode);
    dump_req = 1;
    tick();
    dump_req = 0;
    chk("latency_valid", 32'(bus.tx_valid), 32'd1);
    chk("latency_sof", 32'(bus.tx_data), 32'hF0);
    n = 0;
    while (dones == d0 && n < 20000) begin
      tick();
      n++;
      dump_req = midreq && n == 40;
    end
    dump_req = 0;
    chk("done_seen", 32'(dones != d0), 32'd1);
    repeat (20) tick();
    chk("done_count", dones - d0, 32'd1);
    chk("msg_len", rx.size() - base, NMSG * MSG);
    chk("exp_left", exp_q.size(), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int base, n, d0;
    repeat (3) tick();
    @(negedge CLOCK_25);
    chk("rst_dec", 32'(bus.dec_addr), 32'd0);
    chk("rst_par", 32'(bus.par_addr), 32'd0);
    chk("rst_rden", 32'(bus.rd_en), 32'd0);
    chk("rst_txdata", 32'(bus.tx_data), 32'd0);
    chk("rst_txvalid", 32'(bus.tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    reset = 0;
    repeat (2) tick();

    run_dump(0, 0, base);
    chk("b0_hdr_bank", 32'(rxb(base + 3)), 32'h00);
    chk("b0_first", 32'(rxb(base + 4)), 32'h10);
    chk("b0_last", 32'(rxb(base + 7)), 32'h13);
    chk("b0_eox", 32'(rxb(base + MSG - 1)), 32'hF7);
    chk("b5_bank", 32'(rxb(base + 4 * MSG + 3)), 32'h05);
    chk("b5_first", 32'(rxb(base + 4 * MSG + 4)), 32'h24);
    chk("b5_last", 32'(rxb(base + 4 * MSG + 7)), 32'h27);
    chk("data_gap", rxt(base + 5) - rxt(base + 4), RD_LAT + 2);
    chk("hdr_gap", rxt(base + 3) - rxt(base), 32'd3);

    bp = 1;
    run_dump(0, 0, base);
    bp = 0;
    chk("bp_b3_bank", 32'(rxb(base + 3 * MSG + 3)), 32'h03);

    run_dump(1, 0, base);
    chk("mask_b0", 32'(rxb(base + 4)), 32'h7F);
    chk("mask_b5", 32'(rxb(base + 4 * MSG + 7)), 32'h7F);

    run_dump(0, 1, base);

    base = rx.size();
    d0 = dones;
    mem_mode = 0;
    build(0);
    dump_req = 1;
    tick();
    dump_req = 0;
    n = 0;
    while (rx.size() - base < 2 * MSG + 5 && n < 2000) begin
      tick();
      n++;
    end
    chk("abort_bank", 32'(bus.dec_addr), 32'd2);
    reset = 1;
    @(negedge CLOCK_25);
    chk("abort_valid", 32'(bus.tx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rden", 32'(bus.rd_en), 32'd0);
    tick();
    reset = 0;
    repeat (2) tick();
    chk("abort_no_done", dones - d0, 32'd0);
    run_dump(0, 0, base);
    chk("restart_sof", 32'(rxb(base)), 32'hF0);
    chk("restart_bank", 32'(rxb(base + 3)), 32'h00);

`ifdef SYX_DUMP_CKSUM_EN
    run_dump(2, 0, base);
    chk("cksum_b1", 32'(rxb(base + MSG + PPB + 4)), 32'h75);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/syx_dump_reader.md
Name: syx_dump_reader

Overview:
- Parameter readback engine: the read-side counterpart of the SysEx write path that drives bank select (dec_addr) and data_ready strobes.
- On request, walks each enabled parameter bank and reads every parameter slot through the bank decoder's read port.
- Serialises the results as one SysEx dump message per bank to the MIDI transmit byte interface.
- Sits between the synth parameter RAM banks and the MIDI UART TX.

Parameters:
- BANKS, 6, number of bank indices walked (0..BANKS-1); max 8.
- PARS_PER_BANK, 64, parameter slots per bank (1..128).
- SKIP_MASK, 6'b010000, bit b=1 means bank b is skipped (bank 4 has no decoder line).
- RD_LAT, 2, cycles from rd_en to valid rd_data (1..4).
- MFR_ID, 8'h7D, manufacturer byte.
- DEV_ID, 8'h00, device byte.

Ports:
- CLOCK_25  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dump_req  in  1  single-cycle start pulse.
- dec_addr  out  3  bank index presented to the bank decoder.
- par_addr  out  7  parameter slot within the bank.
- rd_en  out  1  one-cycle read strobe.
- rd_data  in  8  parameter value; only bits [6:0] are used.
- tx_data  out  8  byte to MIDI TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  TX accepts the byte.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the final F7 is accepted.

Behaviour:
- Reset values: dec_addr=0, par_addr=0, rd_en=0, tx_data=0, tx_valid=0, busy=0, done=0. All registers are async-cleared. Reset mid-dump aborts immediately; no F7 is emitted.
- States: IDLE, HDR, RD_ISSUE, RD_WAIT, SEND, CKSUM, EOX, NEXT, FIN.
- IDLE: on dump_req, set busy=1 and bank to the first bank not set in SKIP_MASK, then go to HDR. If every bank is masked, pulse done the next cycle and remain idle.
- dump_req while busy is ignored.
- HDR: send 4 bytes in order: F0, MFR_ID, DEV_ID, {5'b0,bank}.
- RD_ISSUE: rd_en=1 for exactly 1 cycle. dec_addr and par_addr are stable from this cycle until rd_data has been captured.
- RD_WAIT: count RD_LAT cycles, then capture {1'b0,rd_data[6:0]}.
- SEND: present the captured byte. On the last slot (par_addr=PARS_PER_BANK-1) go to CKSUM or EOX; otherwise increment par_addr and return to RD_ISSUE.
- EOX: send F7, then NEXT.
- NEXT: advance bank, skipping masked banks, and reset par_addr=0. Go to HDR, or to FIN when bank would reach BANKS.
- FIN: done=1 for 1 cycle, busy=0, return to IDLE.
- TX handshake:
  - A transfer completes when tx_valid and tx_ready are both high on the same CLOCK_25 edge.
  - tx_data must not change while tx_valid is high and not yet accepted.
  - tx_valid is never withdrawn before acceptance.
  - tx_ready may be held high indefinitely; a back-to-back byte may follow on the next cycle.
- Latency: with dump_req at cycle N, F0 appears with tx_valid at cycle N+1.
- Throughput with tx_ready held at 1: 1 + 1 + RD_LAT cycles per data byte.
- All emitted data bytes have bit7=0. Only F0 and F7 have bit7=1.
- Counters never wrap: par_addr stops at PARS_PER_BANK-1 and bank stops at BANKS-1.

Optional Feature:
- Macro: SYX_DUMP_CKSUM_EN.
- Defined: CKSUM state sends one checksum byte before F7. Checksum = (-(bank + sum of data bytes)) & 7'h7F, accumulated in an 8-bit register cleared in HDR. Message length is 6+PARS_PER_BANK bytes.
- Undefined: CKSUM state and accumulator are absent; SEND goes straight to EOX. Message length is 5+PARS_PER_BANK bytes.

Decomposition:
- Shared package syx_pkg holds:
  - constants SYX_SOX=8'hF0, SYX_EOX=8'hF7, SYX_DATA_MASK=8'h7F;
  - the state enum typedef syx_dump_state_t.
- One natural sub-module, syx_tx_hold: a single-entry valid/ready output register that holds tx_data/tx_valid until acceptance. The FSM loads it and waits on its empty flag.

Test Plan:
- Basic dump: PARS_PER_BANK=4, RD_LAT=2, SKIP_MASK=6'b010000, memory model returns 8'h10+bank*4+slot, tx_ready=1 → stream is F0 7D 00 00 10 11 12 13 F7, ... (bank 4 absent) ... F0 7D 00 05 24 25 26 27 F7; done pulses once.
- Backpressure: toggle tx_ready randomly (~30%) → identical byte stream. tx_data is unchanged while tx_valid=1 and tx_ready=0; no byte is duplicated or dropped.
- Bit7 masking: rd_data=8'hFF for all slots → every data byte is 8'h7F.
- Request while busy: second dump_req mid-dump → ignored; exactly 5 messages and 1 done.
- Reset mid-dump: assert reset during bank 2 SEND → next cycle tx_valid=0, busy=0, rd_en=0. A fresh dump_req after reset restarts from bank 0 with F0.
- SYX_DUMP_CKSUM_EN: bank 1, data 01 02 03 04 → checksum byte 8'h75 before F7.
